// File: rtl/aes_kb_seal_if.sv
// Signal bundle between the key-blob sealer and its environment: command, md5 write port,
// AES core port and result handshake.
interface aes_kb_seal_if;
  logic         stall;
  logic         start;
  logic [447:0] kb;
  logic         busy;

  logic         md5_w;
  logic [3:0]   md5_wa;
  logic [31:0]  md5_data;
  logic         md5_start;
  logic         md5_done;
  logic [127:0] md5_digest;

  logic         aes_start;
  logic [127:0] aes_in;
  logic [127:0] aes_key;
  logic [127:0] aes_out;

  logic [127:0] out_buf;
  logic [127:0] out_key;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  // Sealer side.
  modport master (
    input  stall, start, kb, md5_done, md5_digest, aes_out, out_ready,
    output busy, md5_w, md5_wa, md5_data, md5_start, aes_start, aes_in, aes_key,
           out_buf, out_key, out_valid, err
  );

  // Environment side: md5 core, AES core and result consumer.
  modport slave (
    output stall, start, kb, md5_done, md5_digest, aes_out, out_ready,
    input  busy, md5_w, md5_wa, md5_data, md5_start, aes_start, aes_in, aes_key,
           out_buf, out_key, out_valid, err
  );
endinterface

// File: rtl/aes_kb_seal.sv
// Key-blob sealer: streams the padded blob into an md5 core, then encrypts the digest H
// with itself on a fixed-latency AES core and hands out (AES(H,H), H).
module aes_kb_seal #(
  parameter int unsigned AES_LAT     = 38,
  parameter int unsigned MD5_TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  aes_kb_seal_if.master bus
);

  localparam int unsigned TcntW = (MD5_TIMEOUT > 2) ? $clog2(MD5_TIMEOUT) : 1;
  localparam int unsigned AcntW = $clog2(AES_LAT + 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(MD5_TIMEOUT - 1);
  localparam logic [AcntW-1:0] AcntLast = AcntW'(AES_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StWaitMd5,
    StAes,
    StOut
  } state_e;

  state_e             state_q, state_d;
  logic [447:0]       kb_q, kb_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;
  logic [AcntW-1:0]   acnt_q, acnt_d;
  logic [127:0]       h_q, h_d;
  logic [127:0]       obuf_q, obuf_d;
  logic [127:0]       okey_q, okey_d;
  logic [3:0]         wa_q, wa_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               md5_w_c, md5_start_c, aes_start_c, err_c;
  logic               md5_w;
  logic [511:0]       block;
  logic [31:0]        word;

  // Fixed padding occupies the two top words of the block.
  assign block = {32'h8000_0000, 32'h0000_0000, kb_q};
  assign word  = block[{wcnt_q, 5'b0} +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kb_q    <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      acnt_q  <= '0;
      h_q     <= '0;
      obuf_q  <= '0;
      okey_q  <= '0;
      wa_q    <= '0;
      wdata_q <= '0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      kb_q    <= kb_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      acnt_q  <= acnt_d;
      h_q     <= h_d;
      obuf_q  <= obuf_d;
      okey_q  <= okey_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kb_d        = kb_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    acnt_d      = acnt_q;
    h_d         = h_q;
    obuf_d      = obuf_q;
    okey_d      = okey_q;
    wa_d        = wa_q;
    wdata_d     = wdata_q;
    md5_w_c     = 1'b0;
    md5_start_c = 1'b0;
    aes_start_c = 1'b0;
    err_c       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          kb_d    = bus.kb;
          wcnt_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        md5_w_c = 1'b1;
        wa_d    = wcnt_q;
        wdata_d = word;
        wcnt_d  = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15) begin
          state_d = StKick;
        end
      end
      StKick: begin
        md5_start_c = 1'b1;
        tcnt_d      = '0;
        state_d     = StWaitMd5;
      end
      StWaitMd5: begin
        if (bus.md5_done) begin
          h_d     = bus.md5_digest;
          acnt_d  = '0;
          state_d = StAes;
        end else if (tcnt_q == TcntLast) begin
          err_c   = 1'b1;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StAes: begin
        aes_start_c = (acnt_q == '0);
        if (acnt_q == AcntLast) begin
          obuf_d  = bus.aes_out;
          okey_d  = h_q;
          state_d = StOut;
        end else begin
          acnt_d = acnt_q + 1'b1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are suppressed while stalled; the frozen state re-issues them afterwards.
  assign md5_w         = md5_w_c & ~bus.stall;
  assign bus.md5_w     = md5_w;
  assign bus.md5_start = md5_start_c & ~bus.stall;
  assign bus.aes_start = aes_start_c & ~bus.stall;
  assign bus.err       = err_c & ~bus.stall;

  // Address/data show the live word during a write and hold the last written one otherwise.
  assign bus.md5_wa    = md5_w ? wcnt_q : wa_q;
  assign bus.md5_data  = md5_w ? word : wdata_q;

  assign bus.busy      = (state_q != StIdle);
  assign bus.aes_in    = h_q;
  assign bus.aes_key   = h_q;
  assign bus.out_buf   = obuf_q;
  assign bus.out_key   = okey_q;
  assign bus.out_valid = (state_q == StOut);

endmodule
